eth_tx_pkt_sched: RTL and testbench

//  Packet-granular round-robin scheduler sharing the 10GE MAC transmit packet interface among NUM_SRC requesters.

---
 rtl/eth_tx_pkg.sv | 31 +++
 rtl/eth_rr_arbiter.sv | 26 ++
 rtl/eth_tx_pkt_sched.sv | 157 +++++++++++++++
 tb/tb_eth_tx_pkt_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types, widths and round-robin pick for the 10GE TX packet scheduler
package eth_tx_pkg;

    localparam int DATA_W  = 64;
    localparam int MOD_W   = 3;
    localparam int MAX_SRC = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Walks from the highest offset down so the last hit is the first requester at/after ptr.
    function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
        logic [MAX_SRC-1:0] gnt;
        int idx;
        gnt = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) begin
                    gnt = MAX_SRC'(1) << idx;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// rtl/eth_rr_arbiter.sv - combinational one-hot round-robin grant from a request vector and pointer
module eth_rr_arbiter
    import eth_tx_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [MAX_SRC-1:0] req_ext;
    logic [MAX_SRC-1:0] gnt_ext;
    logic               unused_gnt_hi;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req_i;
        gnt_ext          = rr_pick(req_ext, 3'(ptr_i), N);
        grant_o          = gnt_ext[N-1:0];
    end

    assign unused_gnt_hi = ^gnt_ext;

endmodule

// File: rtl/eth_tx_pkt_sched.sv
// rtl/eth_tx_pkt_sched.sv - packet-granular round-robin scheduler feeding the 10GE MAC pkt_tx port
module eth_tx_pkt_sched
    import eth_tx_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    localparam int IW      = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_en,
    input  logic [NUM_SRC-1:0]         src_val,
    input  logic [NUM_SRC-1:0]         src_sop,
    input  logic [NUM_SRC-1:0]         src_eop,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    input  logic [NUM_SRC*MOD_W-1:0]   src_mod,
    output logic [NUM_SRC-1:0]         src_rdy,
    output logic [DATA_W-1:0]          pkt_tx_data,
    output logic                       pkt_tx_val,
    output logic                       pkt_tx_sop,
    output logic                       pkt_tx_eop,
    output logic [MOD_W-1:0]           pkt_tx_mod,
    input  logic                       pkt_tx_full,
    output logic                       busy,
    output logic [IW-1:0]              grant_idx,
    output logic                       pkt_done,
    output logic                       err_frame
);

    sched_state_t      state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              val_q, val_d, sop_q, sop_d, eop_q, eop_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              done_q, done_d, err_q, err_d;

    logic [NUM_SRC-1:0] req, mis, mis_pick, arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [DATA_W-1:0]  g_data;
    logic [MOD_W-1:0]   g_mod;
    logic               g_val, g_sop, g_eop;

    assign req      = src_val & src_sop;
    assign mis      = src_val & ~src_sop;
    assign mis_pick = mis & (~mis + 1'b1);

    eth_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IW'(i);
            end
        end
    end

    assign g_data = src_data[int'(gidx_q)*DATA_W +: DATA_W];
    assign g_mod  = src_mod[int'(gidx_q)*MOD_W +: MOD_W];
    assign g_val  = src_val[gidx_q];
    assign g_sop  = src_sop[gidx_q];
    assign g_eop  = src_eop[gidx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        first_d = first_q;
        data_d  = '0;
        val_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        mod_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        src_rdy = '0;
        case (state_q)
            IDLE: begin
                if (cfg_en) begin
                    if (|req) begin
                        gidx_d  = arb_idx;
                        first_d = 1'b1;
                        state_d = XFER;
                    end else if (|mis) begin
                        // Misframed words are discarded so a broken source cannot stall the port.
                        src_rdy = mis_pick;
                        err_d   = 1'b1;
                    end
                end
            end
            XFER: begin
                if (g_val && !pkt_tx_full) begin
                    src_rdy[gidx_q] = 1'b1;
                    val_d   = 1'b1;
                    data_d  = g_data;
                    sop_d   = first_q;
                    eop_d   = g_eop;
                    mod_d   = g_eop ? g_mod : '0;
                    err_d   = g_sop & ~first_q;
                    first_d = 1'b0;
                    if (g_eop) begin
                        done_d  = 1'b1;
                        ptr_d   = (int'(gidx_q) == NUM_SRC - 1) ? '0 : gidx_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            src_rdy = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            mod_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            first_q <= first_d;
            data_q  <= data_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            mod_q   <= mod_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pkt_tx_data = data_q;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = mod_q;
    assign busy        = (state_q == XFER);
    assign grant_idx   = gidx_q;
    assign pkt_done    = done_q;
    assign err_frame   = err_q;

endmodule

// File: tb/tb_eth_tx_pkt_sched.sv
// tb/tb_eth_tx_pkt_sched.sv - scoreboard bench for the TX packet scheduler with two sources
module tb_eth_tx_pkt_sched;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    logic         clk, rst, cfg_en, pkt_tx_full;
    logic [1:0]   src_val, src_sop, src_eop, src_rdy;
    logic [127:0] src_data;
    logic [5:0]   src_mod;
    logic [63:0]  pkt_tx_data;
    logic         pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]   pkt_tx_mod;
    logic         busy, pkt_done, err_frame;
    logic         grant_idx;

    int    checks, errors, cyc, drop_errs, done_bad, full_viol, last_eop_cyc;
    word_t exp_q[$], obs_q[$], src0_q[$], src1_q[$];
    int    gap_q[$];
    logic  grant_log[$];
    logic [1:0] rdy_s;
    logic  prev_busy;

    eth_tx_pkt_sched #(.NUM_SRC(2)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en),
        .src_val(src_val), .src_sop(src_sop), .src_eop(src_eop),
        .src_data(src_data), .src_mod(src_mod), .src_rdy(src_rdy),
        .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
        .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
        .busy(busy), .grant_idx(grant_idx), .pkt_done(pkt_done), .err_frame(err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_srcs();
        src_val = '0; src_sop = '0; src_eop = '0; src_data = '0; src_mod = '0;
        if (src0_q.size() > 0) begin
            src_val[0] = 1'b1; src_sop[0] = src0_q[0].sop; src_eop[0] = src0_q[0].eop;
            src_data[63:0] = src0_q[0].data; src_mod[2:0] = src0_q[0].mod;
        end
        if (src1_q.size() > 0) begin
            src_val[1] = 1'b1; src_sop[1] = src1_q[0].sop; src_eop[1] = src1_q[0].eop;
            src_data[127:64] = src1_q[0].data; src_mod[5:3] = src1_q[0].mod;
        end
    endtask

    task automatic run_cycle();
        drive_srcs();
        #2;
        rdy_s = src_rdy;
        if (pkt_tx_full && rdy_s != 2'b00) full_viol++;
        @(posedge clk);
        #1;
        cyc++;
        if (pkt_tx_val) begin
            obs_q.push_back(word_t'{pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, err_frame});
            if (pkt_tx_sop) gap_q.push_back(cyc - last_eop_cyc - 1);
            if (pkt_tx_eop) last_eop_cyc = cyc;
        end else if (err_frame) begin
            drop_errs++;
        end
        if (pkt_done !== (pkt_tx_val & pkt_tx_eop)) done_bad++;
        if (busy && !prev_busy) grant_log.push_back(grant_idx);
        prev_busy = busy;
        if (rdy_s[0] && src0_q.size() > 0) void'(src0_q.pop_front());
        if (rdy_s[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || busy || pkt_tx_val) && n < budget) begin
            run_cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: ran %0d cycles, required fewer than %0d", name, n, budget);
        end
        run_cycle();
        run_cycle();
    endtask

    task automatic add_pkt(input int s, input int tid, input int p, input int n,
                           input logic [2:0] emod, input int errw);
        word_t sw, ew;
        for (int w = 0; w < n; w++) begin
            sw.data = {8'(tid), 8'(s), 8'(p), 8'(w), 32'($urandom)};
            sw.sop  = (w == 0) || (w == errw);
            sw.eop  = (w == n - 1);
            sw.mod  = sw.eop ? emod : 3'($urandom_range(1, 7));
            sw.err  = 1'b0;
            ew      = sw;
            ew.sop  = (w == 0);
            ew.mod  = sw.eop ? emod : 3'd0;
            ew.err  = (w == errw) && (w != 0);
            if (s == 0) src0_q.push_back(sw); else src1_q.push_back(sw);
            exp_q.push_back(ew);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en = 1'b1; pkt_tx_full = 1'b0;
        src_val = '0; src_sop = '0; src_eop = '0; src_data = '0; src_mod = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_done, err_frame} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 00000000",
                     {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_done, err_frame});
        end
        checks++;
        if (pkt_tx_data !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h, expected 0", pkt_tx_data);
        end
        checks++;
        if ({busy, grant_idx} !== 2'b00) begin
            errors++; $display("FAIL reset_state: got busy/grant %b, expected 00", {busy, grant_idx});
        end
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++; $display("FAIL reset_rdy: got %b, expected 00", src_rdy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_pkt();
        grant_log.delete();
        add_pkt(0, 1, 0, 3, 3'd5, -1);
        run_until_idle(40, "t1");
        while (exp_q.size() > 0) begin
            word_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL t1_stream: got no word, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL t1_stream: got %h, expected %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t1_extra: got %0d extra words, expected 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (grant_log.size() != 1 || grant_log[0] !== 1'b0) begin
            errors++; $display("FAIL t1_grant: got %0d grants, expected one grant to source 0", grant_log.size());
        end
        checks++;
        if (done_bad != 0) begin errors++; $display("FAIL t1_done: got %0d misaligned pkt_done, expected 0", done_bad); end
    endtask

    task automatic test_back_to_back();
        logic exp_g;
        grant_log.delete(); gap_q.delete();
        // Pointer sits at 1 after source 0 finished, so source 1 leads.
        for (int p = 0; p < 6; p++) add_pkt((p % 2 == 0) ? 1 : 0, 2, p, 2, 3'(p + 1), -1);
        run_until_idle(80, "t2");
        while (exp_q.size() > 0) begin
            word_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL t2_stream: got no word, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL t2_stream: got %h, expected %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t2_extra: got %0d extra words, expected 0", obs_q.size()); obs_q.delete();
        end
        for (int p = 0; p < 6; p++) begin
            exp_g = (p % 2 == 0);
            checks++;
            if (grant_log.size() == 0) begin
                errors++; $display("FAIL t2_grant%0d: got no grant, expected %0d", p, exp_g);
            end else if (grant_log[0] !== exp_g) begin
                errors++; $display("FAIL t2_grant%0d: got %0d, expected %0d", p, grant_log[0], exp_g);
                void'(grant_log.pop_front());
            end else begin
                void'(grant_log.pop_front());
            end
        end
        if (gap_q.size() > 0) void'(gap_q.pop_front());
        checks++;
        if (gap_q.size() != 5) begin errors++; $display("FAIL t2_gapcount: got %0d, expected 5", gap_q.size()); end
        while (gap_q.size() > 0) begin
            int g;
            g = gap_q.pop_front();
            checks++;
            if (g != 1) begin errors++; $display("FAIL t2_gap: got %0d idle cycles, expected 1", g); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        full_viol = 0;
        add_pkt(0, 3, 0, 6, 3'd3, -1);
        n = 0;
        while (src0_q.size() > 4 && n < 20) begin run_cycle(); n++; end
        pkt_tx_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            checks++;
            if (rdy_s !== 2'b00) begin errors++; $display("FAIL t3_rdy_full%0d: got %b, expected 00", k, rdy_s); end
        end
        pkt_tx_full = 1'b0;
        run_until_idle(40, "t3");
        while (exp_q.size() > 0) begin
            word_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL t3_stream: got no word, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL t3_stream: got %h, expected %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t3_extra: got %0d extra words, expected 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (full_viol != 0) begin errors++; $display("FAIL t3_full_accept: got %0d, expected 0", full_viol); end
    endtask

    task automatic test_misframe();
        word_t sw;
        drop_errs = 0;
        sw = '{data: 64'hBAD0_0000_0000_0001, sop: 1'b0, eop: 1'b0, mod: 3'd2, err: 1'b0};
        src1_q.push_back(sw);
        repeat (4) run_cycle();
        checks++;
        if (drop_errs != 1) begin errors++; $display("FAIL t4_err_pulse: got %0d, expected 1", drop_errs); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t4_issued: got %0d words, expected 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (src1_q.size() != 0) begin errors++; $display("FAIL t4_drop: got %0d words left, expected 0", src1_q.size()); end
        src1_q.delete();
    endtask

    task automatic test_mid_sop();
        drop_errs = 0;
        add_pkt(0, 5, 0, 4, 3'd0, 2);
        run_until_idle(40, "t5");
        while (exp_q.size() > 0) begin
            word_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL t5_stream: got no word, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL t5_stream: got %h, expected %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t5_extra: got %0d extra words, expected 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (drop_errs != 0) begin errors++; $display("FAIL t5_drop: got %0d, expected 0", drop_errs); end
    endtask

    task automatic test_cfg_en();
        int n;
        grant_log.delete();
        add_pkt(0, 6, 0, 4, 3'd2, -1);
        n = 0;
        while (src0_q.size() > 3 && n < 20) begin run_cycle(); n++; end
        cfg_en = 1'b0;
        add_pkt(1, 6, 1, 2, 3'd7, -1);
        repeat (12) run_cycle();
        checks++;
        if (src0_q.size() != 0) begin errors++; $display("FAIL t6_finish: got %0d words left, expected 0", src0_q.size()); end
        checks++;
        if (src1_q.size() != 2) begin errors++; $display("FAIL t6_hold: got %0d words left, expected 2", src1_q.size()); end
        checks++;
        if ({busy, grant_idx} !== 2'b00) begin
            errors++; $display("FAIL t6_idle: got busy/grant %b, expected 00", {busy, grant_idx});
        end
        cfg_en = 1'b1;
        run_until_idle(40, "t6");
        while (exp_q.size() > 0) begin
            word_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL t6_stream: got no word, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL t6_stream: got %h, expected %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t6_extra: got %0d extra words, expected 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (grant_log.size() != 2 || grant_log[1] !== 1'b1) begin
            errors++; $display("FAIL t6_grants: got %0d grants, expected 2 ending with source 1", grant_log.size());
        end
        checks++;
        if (done_bad != 0) begin errors++; $display("FAIL t6_done: got %0d misaligned pkt_done, expected 0", done_bad); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; drop_errs = 0; done_bad = 0; full_viol = 0;
        last_eop_cyc = 0; prev_busy = 1'b0; rdy_s = '0;
        test_reset();
        test_single_pkt();
        test_back_to_back();
        test_backpressure();
        test_misframe();
        test_mid_sop();
        test_cfg_en();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
